// File: rtl/trap_redirect_unit_pkg.sv
// Shared constants for the writeback trap/redirect unit:
// CSR addresses, cause codes, PC mux encodings and mstatus bit positions.
package trap_redirect_unit_pkg;

    localparam logic [11:0] CSR_MSTATUS  = 12'h300;
    localparam logic [11:0] CSR_MTVEC    = 12'h305;
    localparam logic [11:0] CSR_MEPC     = 12'h341;
    localparam logic [11:0] CSR_MCAUSE   = 12'h342;
    localparam logic [11:0] CSR_MTVAL    = 12'h343;
    localparam logic [11:0] CSR_MCYCLE   = 12'hB00;
    localparam logic [11:0] CSR_MINSTRET = 12'hB02;

    localparam logic [63:0] CAUSE_IAM   = 64'd0;
    localparam logic [63:0] CAUSE_IAF   = 64'd1;
    localparam logic [63:0] CAUSE_II    = 64'd2;
    localparam logic [63:0] CAUSE_BP    = 64'd3;
    localparam logic [63:0] CAUSE_LAM   = 64'd4;
    localparam logic [63:0] CAUSE_SAM   = 64'd6;
    localparam logic [63:0] CAUSE_ECALL = 64'd11;

    typedef enum logic [1:0] {
        PCMUX_SEQ  = 2'd0,
        PCMUX_BR   = 2'd1,
        PCMUX_TRAP = 2'd2,
        PCMUX_MRET = 2'd3
    } pcmux_e;

    typedef enum logic {
        ST_RUN   = 1'b0,
        ST_FLUSH = 1'b1
    } state_e;

    localparam int MSTATUS_MIE    = 3;
    localparam int MSTATUS_MPIE   = 7;
    localparam int MSTATUS_MPP_LO = 11;
    localparam int MSTATUS_MPP_HI = 12;

endpackage

// File: rtl/trap_redirect_unit_csr_file.sv
// Machine-mode trap CSRs: storage, write masking, counters and the
// combinational decode read port.
module trap_csr_file
    import trap_redirect_unit_pkg::*;
#(
    parameter logic [63:0] RESET_MTVEC = 64'h0000_0000_0000_0100
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        trap,
    input  logic [63:0] trap_cause,
    input  logic [63:0] trap_epc,
    input  logic [63:0] trap_tval,
    input  logic        mret,
    input  logic        retire,
    input  logic        we,
    input  logic [11:0] waddr,
    input  logic [63:0] wdata,
    input  logic [11:0] raddr,
    output logic [63:0] rdata,
    output logic [63:0] mtvec,
    output logic [63:0] mepc,
    output logic [63:0] mcause
);

    logic        mie;
    logic        mpie;
    logic [63:0] mtval;
    logic [63:0] mcycle;
    logic [63:0] minstret;
    logic [63:0] mstatus_rd;

    logic wr_mstatus;
    logic wr_mtvec;
    logic wr_mepc;
    logic wr_mcause;
    logic wr_mtval;
    logic wr_mcycle;
    logic wr_minstret;

    assign wr_mstatus  = we && (waddr == CSR_MSTATUS);
    assign wr_mtvec    = we && (waddr == CSR_MTVEC);
    assign wr_mepc     = we && (waddr == CSR_MEPC);
    assign wr_mcause   = we && (waddr == CSR_MCAUSE);
    assign wr_mtval    = we && (waddr == CSR_MTVAL);
    assign wr_mcycle   = we && (waddr == CSR_MCYCLE);
    assign wr_minstret = we && (waddr == CSR_MINSTRET);

    // Assemble mstatus view: only MIE/MPIE are stored, MPP is fixed to M-mode.
    always_comb begin
        mstatus_rd = '0;
        mstatus_rd[MSTATUS_MIE] = mie;
        mstatus_rd[MSTATUS_MPIE] = mpie;
        mstatus_rd[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = 2'b11;
    end

    // Decode read port; no forwarding of a same-cycle write.
    always_comb begin
        rdata = '0;
        unique case (raddr)
            CSR_MSTATUS:  rdata = mstatus_rd;
            CSR_MTVEC:    rdata = mtvec;
            CSR_MEPC:     rdata = mepc;
            CSR_MCAUSE:   rdata = mcause;
            CSR_MTVAL:    rdata = mtval;
            CSR_MCYCLE:   rdata = mcycle;
            CSR_MINSTRET: rdata = minstret;
            default:      rdata = '0;
        endcase
    end

    // Register update: traps and MRET take precedence over software writes.
    always_ff @(posedge clk) begin
        if (reset) begin
            mie      <= 1'b0;
            mpie     <= 1'b0;
            mtvec    <= RESET_MTVEC;
            mepc     <= '0;
            mcause   <= '0;
            mtval    <= '0;
            mcycle   <= '0;
            minstret <= '0;
        end else begin
            mcycle <= wr_mcycle ? wdata : mcycle + 64'd1;
            if (wr_minstret) begin
                minstret <= wdata;
            end else if (retire) begin
                minstret <= minstret + 64'd1;
            end
            if (trap) begin
                mepc   <= trap_epc;
                mcause <= trap_cause;
                mtval  <= trap_tval;
                mpie   <= mie;
                mie    <= 1'b0;
            end else if (mret) begin
                mie  <= mpie;
                mpie <= 1'b1;
            end else begin
                if (wr_mstatus) begin
                    mie  <= wdata[MSTATUS_MIE];
                    mpie <= wdata[MSTATUS_MPIE];
                end
                if (wr_mtvec)  mtvec  <= wdata & ~64'd3;
                if (wr_mepc)   mepc   <= wdata & ~64'd3;
                if (wr_mcause) mcause <= wdata;
                if (wr_mtval)  mtval  <= wdata;
            end
        end
    end

endmodule

// File: rtl/trap_redirect_unit.sv
// Writeback-side trap/MRET/branch redirect producer with a fixed-length
// pipeline squash after trap and MRET redirects.
module trap_redirect_unit
    import trap_redirect_unit_pkg::*;
#(
    parameter int          FLUSH_CYCLES = 4,
    parameter logic [63:0] RESET_MTVEC  = 64'h0000_0000_0000_0100
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        WB_V,
    input  logic [63:0] WB_PC,
    input  logic        WB_IAF,
    input  logic        WB_II,
    input  logic        WB_IAM,
    input  logic        WB_ECALL,
    input  logic        WB_EBREAK,
    input  logic        WB_LAM,
    input  logic        WB_SAM,
    input  logic [63:0] WB_TVAL,
    input  logic        WB_MRET,
    input  logic        WB_BR_TAKEN,
    input  logic [63:0] WB_BR_TARGET,
    input  logic        WB_CSR_WE,
    input  logic [11:0] WB_CSR_ADDR,
    input  logic [63:0] WB_CSR_WDATA,
    input  logic [11:0] DE_CSR_ADDR,
    output logic [63:0] DE_CSR_RDATA,
    output logic [63:0] DE_MTVEC,
    output logic [1:0]  WB_PC_MUX,
    output logic [63:0] WB_BR_JMP_PC,
    output logic        WB_FLUSH,
    output logic [63:0] WB_CAUSE
);

    localparam int CW = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;

    state_e      state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    pcmux_e      mux_q, mux_d;
    logic [63:0] pc_q, pc_d;
    logic        flush_q, flush_d;

    logic        exc;
    logic        tval_zero;
    logic [63:0] cause;
    logic        eff_v;
    logic        trap;
    logic        mret;
    logic        br;
    logic        retire;
    logic        csr_we;
    logic [63:0] mtvec;
    logic [63:0] mepc;

    // Fixed exception priority; only the winning cause is reported.
    always_comb begin
        exc = 1'b1;
        tval_zero = 1'b0;
        cause = '0;
        if (WB_IAF) begin
            cause = CAUSE_IAF;
        end else if (WB_II) begin
            cause = CAUSE_II;
        end else if (WB_IAM) begin
            cause = CAUSE_IAM;
        end else if (WB_EBREAK) begin
            cause = CAUSE_BP;
            tval_zero = 1'b1;
        end else if (WB_ECALL) begin
            cause = CAUSE_ECALL;
            tval_zero = 1'b1;
        end else if (WB_LAM) begin
            cause = CAUSE_LAM;
        end else if (WB_SAM) begin
            cause = CAUSE_SAM;
        end else begin
            exc = 1'b0;
        end
    end

    assign eff_v  = WB_V && (state_q == ST_RUN);
    assign trap   = eff_v && exc;
    assign mret   = eff_v && !exc && WB_MRET;
    assign br     = eff_v && !exc && !WB_MRET && WB_BR_TAKEN;
    assign retire = eff_v && !exc;
    assign csr_we = eff_v && !exc && !WB_MRET && WB_CSR_WE;

    trap_csr_file #(
        .RESET_MTVEC(RESET_MTVEC)
    ) u_csr (
        .clk        (CLK),
        .reset      (RESET),
        .trap       (trap),
        .trap_cause (cause),
        .trap_epc   (WB_PC & ~64'd3),
        .trap_tval  (tval_zero ? 64'd0 : WB_TVAL),
        .mret       (mret),
        .retire     (retire),
        .we         (csr_we),
        .waddr      (WB_CSR_ADDR),
        .wdata      (WB_CSR_WDATA),
        .raddr      (DE_CSR_ADDR),
        .rdata      (DE_CSR_RDATA),
        .mtvec      (mtvec),
        .mepc       (mepc),
        .mcause     (WB_CAUSE)
    );

    // Next-state and next redirect: redirect on trap/MRET/branch, then squash.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        mux_d   = PCMUX_SEQ;
        pc_d    = pc_q;
        flush_d = 1'b0;
        unique case (state_q)
            ST_RUN: begin
                if (trap || mret) begin
                    state_d = ST_FLUSH;
                    cnt_d   = CW'(FLUSH_CYCLES - 1);
                    flush_d = 1'b1;
                    mux_d   = trap ? PCMUX_TRAP : PCMUX_MRET;
                    pc_d    = trap ? mtvec : mepc;
                end else if (br) begin
                    mux_d = PCMUX_BR;
                    pc_d  = WB_BR_TARGET;
                end
            end
            ST_FLUSH: begin
                if (cnt_q == '0) begin
                    state_d = ST_RUN;
                end else begin
                    cnt_d   = cnt_q - CW'(1);
                    flush_d = 1'b1;
                end
            end
            default: state_d = ST_RUN;
        endcase
    end

    // State, flush counter and registered redirect outputs.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q <= ST_RUN;
            cnt_q   <= '0;
            mux_q   <= PCMUX_SEQ;
            pc_q    <= '0;
            flush_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            mux_q   <= mux_d;
            pc_q    <= pc_d;
            flush_q <= flush_d;
        end
    end

    assign WB_PC_MUX    = mux_q;
    assign WB_BR_JMP_PC = pc_q;
    assign WB_FLUSH     = flush_q;
    assign DE_MTVEC     = mtvec;

endmodule

// File: tb/tb_trap_redirect_unit.sv
// Scoreboard bench for trap_redirect_unit: the driver queues the expected
// post-edge outputs, a negedge monitor pops and compares them.
module tb_trap_redirect_unit;

    logic        CLK = 1'b0;
    logic        RESET;
    logic        WB_V;
    logic [63:0] WB_PC;
    logic        WB_IAF, WB_II, WB_IAM, WB_ECALL, WB_EBREAK, WB_LAM, WB_SAM;
    logic [63:0] WB_TVAL;
    logic        WB_MRET;
    logic        WB_BR_TAKEN;
    logic [63:0] WB_BR_TARGET;
    logic        WB_CSR_WE;
    logic [11:0] WB_CSR_ADDR;
    logic [63:0] WB_CSR_WDATA;
    logic [11:0] DE_CSR_ADDR;
    logic [63:0] DE_CSR_RDATA;
    logic [63:0] DE_MTVEC;
    logic [1:0]  WB_PC_MUX;
    logic [63:0] WB_BR_JMP_PC;
    logic        WB_FLUSH;
    logic [63:0] WB_CAUSE;

    typedef struct {
        int          id;
        logic [1:0]  mux;
        logic [63:0] pc;
        logic        flush;
        bit          chk;
        logic [63:0] csr;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;
    int   step = 0;

    localparam logic [11:0] A_MSTATUS  = 12'h300;
    localparam logic [11:0] A_MTVEC    = 12'h305;
    localparam logic [11:0] A_MEPC     = 12'h341;
    localparam logic [11:0] A_MCAUSE   = 12'h342;
    localparam logic [11:0] A_MTVAL    = 12'h343;
    localparam logic [11:0] A_MCYCLE   = 12'hB00;
    localparam logic [11:0] A_MINSTRET = 12'hB02;

    trap_redirect_unit dut (
        .CLK          (CLK),
        .RESET        (RESET),
        .WB_V         (WB_V),
        .WB_PC        (WB_PC),
        .WB_IAF       (WB_IAF),
        .WB_II        (WB_II),
        .WB_IAM       (WB_IAM),
        .WB_ECALL     (WB_ECALL),
        .WB_EBREAK    (WB_EBREAK),
        .WB_LAM       (WB_LAM),
        .WB_SAM       (WB_SAM),
        .WB_TVAL      (WB_TVAL),
        .WB_MRET      (WB_MRET),
        .WB_BR_TAKEN  (WB_BR_TAKEN),
        .WB_BR_TARGET (WB_BR_TARGET),
        .WB_CSR_WE    (WB_CSR_WE),
        .WB_CSR_ADDR  (WB_CSR_ADDR),
        .WB_CSR_WDATA (WB_CSR_WDATA),
        .DE_CSR_ADDR  (DE_CSR_ADDR),
        .DE_CSR_RDATA (DE_CSR_RDATA),
        .DE_MTVEC     (DE_MTVEC),
        .WB_PC_MUX    (WB_PC_MUX),
        .WB_BR_JMP_PC (WB_BR_JMP_PC),
        .WB_FLUSH     (WB_FLUSH),
        .WB_CAUSE     (WB_CAUSE)
    );

    always #5 CLK = ~CLK;

    task automatic clr();
        RESET = 1'b0;
        WB_V = 1'b0;
        WB_PC = '0;
        {WB_IAF, WB_II, WB_IAM, WB_ECALL, WB_EBREAK, WB_LAM, WB_SAM} = '0;
        WB_TVAL = '0;
        WB_MRET = 1'b0;
        WB_BR_TAKEN = 1'b0;
        WB_BR_TARGET = '0;
        WB_CSR_WE = 1'b0;
        WB_CSR_ADDR = '0;
        WB_CSR_WDATA = '0;
        DE_CSR_ADDR = 12'h7FF;
    endtask

    // One clock: queue what the outputs must show after this edge.
    task automatic cyc(input logic [1:0] m, input logic [63:0] p,
                       input logic f, input bit c, input logic [63:0] v);
        exp_t e;
        @(posedge CLK);
        step++;
        e.id = step;
        e.mux = m;
        e.pc = p;
        e.flush = f;
        e.chk = c;
        e.csr = v;
        q.push_back(e);
        @(negedge CLK);
        #1;
        clr();
    endtask

    task automatic cmp(input string nm, input int id,
                       input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s step %0d: got %h expected %h", nm, id, act, exp);
        end
    endtask

    // Monitor: compare the DUT against the oldest queued expectation.
    always @(negedge CLK) begin
        if (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            cmp("pc_mux", e.id, {62'd0, WB_PC_MUX}, {62'd0, e.mux});
            cmp("flush", e.id, {63'd0, WB_FLUSH}, {63'd0, e.flush});
            if (e.mux != 2'd0) cmp("jmp_pc", e.id, WB_BR_JMP_PC, e.pc);
            if (e.chk) cmp("csr_rdata", e.id, DE_CSR_RDATA, e.csr);
        end
    end

    initial begin
        clr();
        // reset state
        RESET = 1; DE_CSR_ADDR = A_MTVEC;   cyc(0, 0, 0, 1, 64'h100);
        RESET = 1; DE_CSR_ADDR = A_MEPC;    cyc(0, 0, 0, 1, 64'h0);
        RESET = 1; DE_CSR_ADDR = A_MSTATUS; cyc(0, 0, 0, 1, 64'h1800);
        // ECALL trap
        WB_V = 1; WB_ECALL = 1; WB_PC = 64'h2004; WB_TVAL = 64'h55;
        DE_CSR_ADDR = A_MEPC;               cyc(2, 64'h100, 1, 1, 64'h2004);
        DE_CSR_ADDR = A_MCAUSE;             cyc(0, 0, 1, 1, 64'd11);
        DE_CSR_ADDR = A_MTVAL;              cyc(0, 0, 1, 1, 64'h0);
        DE_CSR_ADDR = A_MSTATUS;            cyc(0, 0, 1, 1, 64'h1800);
        DE_CSR_ADDR = A_MCYCLE;             cyc(0, 0, 0, 1, 64'd5);
        DE_CSR_ADDR = A_MINSTRET;           cyc(0, 0, 0, 1, 64'd0);
        // II + IAM with a same-cycle mtvec write that must be dropped
        WB_V = 1; WB_II = 1; WB_IAM = 1; WB_TVAL = 64'hDEADBEEF;
        WB_PC = 64'h3000;
        WB_CSR_WE = 1; WB_CSR_ADDR = A_MTVEC; WB_CSR_WDATA = 64'h400;
        DE_CSR_ADDR = A_MCAUSE;             cyc(2, 64'h100, 1, 1, 64'd2);
        DE_CSR_ADDR = A_MTVAL;              cyc(0, 0, 1, 1, 64'hDEADBEEF);
        // inputs during flush are ignored
        WB_V = 1; WB_ECALL = 1;
        WB_CSR_WE = 1; WB_CSR_ADDR = A_MTVEC; WB_CSR_WDATA = 64'h400;
        DE_CSR_ADDR = A_MTVEC;              cyc(0, 0, 1, 1, 64'h100);
        WB_V = 1; WB_EBREAK = 1;
        DE_CSR_ADDR = A_MCAUSE;             cyc(0, 0, 1, 1, 64'd2);
        DE_CSR_ADDR = A_MINSTRET;           cyc(0, 0, 0, 1, 64'd0);
        // trap on the first cycle after flush
        WB_V = 1; WB_LAM = 1; WB_PC = 64'h5008; WB_TVAL = 64'h77;
        DE_CSR_ADDR = A_MCAUSE;             cyc(2, 64'h100, 1, 1, 64'd4);
        DE_CSR_ADDR = A_MTVAL;              cyc(0, 0, 1, 1, 64'h77);
        DE_CSR_ADDR = A_MEPC;               cyc(0, 0, 1, 1, 64'h5008);
                                            cyc(0, 0, 1, 0, 64'h0);
                                            cyc(0, 0, 0, 0, 64'h0);
        // mepc / mstatus writes then MRET
        WB_V = 1; WB_CSR_WE = 1; WB_CSR_ADDR = A_MEPC;
        WB_CSR_WDATA = 64'h3006;
        DE_CSR_ADDR = A_MEPC;               cyc(0, 0, 0, 1, 64'h3004);
        WB_V = 1; WB_CSR_WE = 1; WB_CSR_ADDR = A_MSTATUS;
        WB_CSR_WDATA = 64'h80;
        DE_CSR_ADDR = A_MSTATUS;            cyc(0, 0, 0, 1, 64'h1880);
        WB_V = 1; WB_MRET = 1;
        DE_CSR_ADDR = A_MINSTRET;           cyc(3, 64'h3004, 1, 1, 64'd3);
        DE_CSR_ADDR = A_MSTATUS;            cyc(0, 0, 1, 1, 64'h1888);
                                            cyc(0, 0, 1, 0, 64'h0);
                                            cyc(0, 0, 1, 0, 64'h0);
                                            cyc(0, 0, 0, 0, 64'h0);
        // taken branch: one-cycle redirect, no flush
        WB_V = 1; WB_BR_TAKEN = 1; WB_BR_TARGET = 64'h8000;
        DE_CSR_ADDR = A_MINSTRET;           cyc(1, 64'h8000, 0, 1, 64'd4);
                                            cyc(0, 0, 0, 0, 64'h0);
        // minstret wrap
        WB_V = 1; WB_CSR_WE = 1; WB_CSR_ADDR = A_MINSTRET;
        WB_CSR_WDATA = '1;
        DE_CSR_ADDR = A_MINSTRET;           cyc(0, 0, 0, 1, '1);
        WB_V = 1;
        DE_CSR_ADDR = A_MINSTRET;           cyc(0, 0, 0, 1, 64'd0);
        // unknown address write/read
        WB_V = 1; WB_CSR_WE = 1; WB_CSR_ADDR = 12'h7C0; WB_CSR_WDATA = 64'd5;
        DE_CSR_ADDR = 12'h7C0;              cyc(0, 0, 0, 1, 64'd0);
        // mtvec write masks low bits and is used by the next trap
        WB_V = 1; WB_CSR_WE = 1; WB_CSR_ADDR = A_MTVEC;
        WB_CSR_WDATA = 64'h203;
        DE_CSR_ADDR = A_MTVEC;              cyc(0, 0, 0, 1, 64'h200);
        WB_V = 1; WB_ECALL = 1; WB_PC = 64'h9003;
        DE_CSR_ADDR = A_MEPC;               cyc(2, 64'h200, 1, 1, 64'h9000);
        DE_CSR_ADDR = A_MSTATUS;            cyc(0, 0, 1, 1, 64'h1880);
        // reset on the 2nd flush cycle aborts the flush
        RESET = 1; DE_CSR_ADDR = A_MTVEC;   cyc(0, 0, 0, 1, 64'h100);
        DE_CSR_ADDR = A_MEPC;               cyc(0, 0, 0, 1, 64'h0);
        DE_CSR_ADDR = A_MCYCLE;             cyc(0, 0, 0, 1, 64'd2);
        // exception beats MRET
        WB_V = 1; WB_MRET = 1; WB_IAF = 1; WB_PC = 64'hA000;
        DE_CSR_ADDR = A_MCAUSE;             cyc(2, 64'h100, 1, 1, 64'd1);
        DE_CSR_ADDR = A_MSTATUS;            cyc(0, 0, 1, 1, 64'h1800);

        for (int i = 0; i < 10 && q.size() > 0; i++) @(negedge CLK);
        #2;
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d expectations left, expected 0", q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/trap_redirect_unit.md
Name: trap_redirect_unit

Overview:
- Writeback-side producer of the PC-redirect interface that the fetch stage consumes (WB_PC_MUX, WB_BR_JMP_PC, trap vector).
- Takes each retiring instruction's exception flags, branch outcome and MRET indication, and owns the machine-mode trap CSRs (mstatus, mtvec, mepc, mcause, mtval, mcycle, minstret).
- Issues a registered redirect, then squashes the in-flight pipeline for a fixed number of cycles.
- Sits between the writeback stage and fetch/decode. Decode reads CSRs through its read port.

Parameters:
- FLUSH_CYCLES, 4, cycles WB_V is ignored after a trap or MRET redirect (younger in-flight instructions).
- RESET_MTVEC, 64'h0000_0000_0000_0100, mtvec value after reset.

Ports:
- CLK  in  1  clock
- RESET  in  1  synchronous, active-high reset
- WB_V  in  1  writeback instruction valid
- WB_PC  in  64  PC of writeback instruction
- WB_IAF, WB_II, WB_IAM, WB_ECALL, WB_EBREAK, WB_LAM, WB_SAM  in  1 each  exception flags
- WB_TVAL  in  64  faulting address/instruction bits for mtval
- WB_MRET  in  1  instruction is MRET
- WB_BR_TAKEN  in  1  branch/jump taken
- WB_BR_TARGET  in  64  branch/jump target
- WB_CSR_WE  in  1  CSR write from CSRRW/S/C
- WB_CSR_ADDR  in  12  CSR write address
- WB_CSR_WDATA  in  64  CSR write data (already combined)
- DE_CSR_ADDR  in  12  decode CSR read address
- DE_CSR_RDATA  out  64  combinational CSR read data
- DE_MTVEC  out  64  current mtvec
- WB_PC_MUX  out  2  0 = PC+4, 1 = branch target, 2 = trap vector, 3 = mepc
- WB_BR_JMP_PC  out  64  redirect target for codes 1/2/3
- WB_FLUSH  out  1  squash all stages younger than writeback
- WB_CAUSE  out  64  last mcause (debug/trace)

Behaviour:
- Reset (RESET=1 at a CLK edge):
  - WB_PC_MUX=0, WB_BR_JMP_PC=0, WB_FLUSH=0, WB_CAUSE=0.
  - mstatus: MIE=0, MPIE=0, MPP=2'b11.
  - mtvec=RESET_MTVEC; mepc, mcause, mtval, mcycle, minstret = 0.
  - FSM enters RUN and the flush counter clears.
  - Reset mid-flush aborts the flush immediately.
- Effective valid is WB_V && state==RUN. Inputs in FLUSH are ignored entirely: no CSR write, no minstret increment.
- Exception priority, highest first: IAF (cause 1), II (2), IAM (0), EBREAK (3), ECALL (11), LAM (4), SAM (6). Multiple flags select only the highest.
- Trap (effective valid and any flag set), applied at the next edge:
  - mepc = {WB_PC[63:2], 2'b00}; mcause = code; mtval = WB_TVAL (0 for ECALL/EBREAK).
  - MPIE = MIE, MIE = 0.
  - WB_PC_MUX = 2, WB_BR_JMP_PC = mtvec. The mtvec used is the pre-edge value.
  - WB_FLUSH = 1; state moves to FLUSH with counter = FLUSH_CYCLES-1.
  - Any CSR write in the same cycle is dropped. minstret does not increment.
- MRET (effective valid, no exception flag):
  - MIE = MPIE, MPIE = 1.
  - WB_PC_MUX = 3, WB_BR_JMP_PC = pre-edge mepc.
  - FLUSH entered as for a trap; minstret increments.
  - An exception flag takes precedence over MRET.
- Taken branch (effective valid, no exception, no MRET):
  - WB_PC_MUX = 1, WB_BR_JMP_PC = WB_BR_TARGET for exactly one cycle.
  - No FSM flush; pipeline-stall logic handles younger instructions.
- Otherwise WB_PC_MUX = 0. Redirect outputs are registered, with 1-cycle latency from the WB inputs.
- FLUSH state:
  - WB_FLUSH = 1 every cycle; WB_PC_MUX returns to 0 after the first cycle.
  - Counter decrements; at 0 the next state is RUN and WB_FLUSH drops.
  - Total flush width is FLUSH_CYCLES cycles.
- CSR writes (effective valid, no trap, no MRET):
  - mtvec: low 2 bits forced to 0 (direct mode only).
  - mepc: low 2 bits forced to 0.
  - mstatus: only bits 3 and 7 are writable; MPP reads 2'b11.
  - mcause, mtval, mcycle, minstret: full width.
  - Unknown address: write ignored.
  - A CSR write to mcycle/minstret overrides that cycle's increment.
- Counters: mcycle increments every non-reset cycle, including FLUSH. minstret increments per effective-valid non-trapping instruction. Both wrap from 2^64-1 to 0.
- CSR reads:
  - Combinational from current registers; unknown address returns 0.
  - A same-cycle write is not forwarded; decode sees the new value next cycle.
- CSR addresses: mstatus 12'h300, mtvec 12'h305, mepc 12'h341, mcause 12'h342, mtval 12'h343, mcycle 12'hB00, minstret 12'hB02.

Decomposition:
- Shared package holds:
  - CSR address constants.
  - Cause codes.
  - PC_MUX encodings (PCMUX_SEQ/BR/TRAP/MRET).
  - mstatus bit indices.
- One natural sub-module: trap_csr_file. It holds the registers, read mux, write masking and counters.
- The top keeps the priority encoder, FSM (RUN/FLUSH), flush counter and redirect registers.

Test Plan:
- Reset, then mtvec=0x100: WB_V=1, WB_ECALL=1, WB_PC=0x2004 → next cycle WB_PC_MUX=2, WB_BR_JMP_PC=0x100, mepc=0x2004, mcause=11, MIE=0, WB_FLUSH high 4 cycles.
- WB_II=1 and WB_IAM=1 together, WB_TVAL=0xDEADBEEF → mcause=2, mtval=0xDEADBEEF. Same-cycle CSR write to mtvec=0x400 is dropped; mtvec stays 0x100.
- Write mepc=0x3006, then MRET with MPIE=1 → WB_PC_MUX=3, target 0x3004, MIE=1, MPIE=1, minstret +1.
- During FLUSH, WB_V=1 with WB_ECALL and a CSR write → no state change, no second redirect. A trap presented the cycle after flush ends is taken normally.
- Taken branch to 0x8000 → WB_PC_MUX=1 for exactly one cycle, WB_FLUSH stays 0. Write minstret=2^64-1, retire one instruction → minstret reads 0.
- RESET asserted on the 2nd flush cycle → next cycle WB_FLUSH=0, WB_PC_MUX=0, mtvec=RESET_MTVEC, mepc=0.
